// File: rtl/rst_ctrl.sv
// System reset controller: merges POR, debounced push-button, watchdog and
// software requests into one registered reset with a guaranteed minimum width.
module rst_ctrl #(
  parameter int unsigned DEBOUNCE = 16,
  parameter int unsigned HOLD     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       wdt_req,
  input  logic       soft_req,
  output logic       rst_o,
  output logic [1:0] cause,
  output logic [7:0] rst_cnt
);

  localparam int unsigned DW = $clog2(DEBOUNCE);
  localparam int unsigned HW = $clog2(HOLD);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_BTN  = 2'd1;
  localparam logic [1:0] CAUSE_WDT  = 2'd2;
  localparam logic [1:0] CAUSE_SOFT = 2'd3;

  typedef enum logic [1:0] {
    S_ASSERT,
    S_HOLD,
    S_RUN
  } state_t;

  state_t        state;
  logic          sync1, sync2;
  logic          btn_db;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hcnt;
  logic [7:0]    cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Accepted level flips only after DEBOUNCE consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (sync2 != btn_db) begin
      if (db_cnt == DB_MAX) begin
        btn_db <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  always_comb begin
    cnt_inc = rst_cnt;
    if (rst_cnt != 8'hFF) cnt_inc = rst_cnt + 8'd1;
  end

  // btn_db is always 1 on entry to HOLD/RUN, so a low level there is a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_ASSERT;
      hcnt    <= '0;
      rst_o   <= 1'b1;
      cause   <= CAUSE_POR;
      rst_cnt <= '0;
    end else begin
      case (state)
        S_ASSERT: begin
          rst_o <= 1'b1;
          if (btn_db) begin
            state <= S_HOLD;
            hcnt  <= '0;
          end
        end
        S_HOLD: begin
          rst_o <= 1'b1;
          if (!btn_db) begin
            state   <= S_ASSERT;
            cause   <= CAUSE_BTN;
            rst_cnt <= cnt_inc;
          end else if (wdt_req) begin
            hcnt    <= '0;
            cause   <= CAUSE_WDT;
            rst_cnt <= cnt_inc;
          end else if (soft_req) begin
            hcnt    <= '0;
            cause   <= CAUSE_SOFT;
            rst_cnt <= cnt_inc;
          end else if (hcnt == HOLD_MAX) begin
            state <= S_RUN;
            rst_o <= 1'b0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_RUN: begin
          rst_o <= 1'b0;
          if (!btn_db) begin
            state   <= S_ASSERT;
            rst_o   <= 1'b1;
            cause   <= CAUSE_BTN;
            rst_cnt <= cnt_inc;
          end else if (wdt_req) begin
            state   <= S_ASSERT;
            rst_o   <= 1'b1;
            cause   <= CAUSE_WDT;
            rst_cnt <= cnt_inc;
          end else if (soft_req) begin
            state   <= S_ASSERT;
            rst_o   <= 1'b1;
            cause   <= CAUSE_SOFT;
            rst_cnt <= cnt_inc;
          end
        end
        default: begin
          state <= S_ASSERT;
          rst_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_ctrl.sv
// Directed testbench for rst_ctrl with DEBOUNCE=4, HOLD=8.
module tb_rst_ctrl;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       btn_n    = 1'b1;
  logic       wdt_req  = 1'b0;
  logic       soft_req = 1'b0;
  logic       rst_o;
  logic [1:0] cause;
  logic [7:0] rst_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  rst_ctrl #(.DEBOUNCE(4), .HOLD(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .wdt_req  (wdt_req),
    .soft_req (soft_req),
    .rst_o    (rst_o),
    .cause    (cause),
    .rst_cnt  (rst_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one active edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // POR
    repeat (3) tick();
    check("por_rst_o", 32'(rst_o), 1);
    check("por_cause", 32'(cause), 0);
    check("por_cnt", 32'(rst_cnt), 0);
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check($sformatf("por_rel_e%0d", e), 32'(rst_o), (e < 9) ? 1 : 0);
    end
    check("por_rel_cause", 32'(cause), 0);
    check("por_rel_cnt", 32'(rst_cnt), 0);

    // Glitch of 3 cycles is rejected
    btn_n = 1'b0;
    repeat (3) tick();
    btn_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("glitch_e%0d", e), 32'(rst_o), 0);
    end
    check("glitch_cnt", 32'(rst_cnt), 0);

    // Button press: 20 cycles low
    btn_n = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check($sformatf("btn_fall_e%0d", e), 32'(rst_o), (e >= 7) ? 1 : 0);
    end
    btn_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      check($sformatf("btn_rise_e%0d", e), 32'(rst_o), (e < 15) ? 1 : 0);
    end
    check("btn_cause", 32'(cause), 1);
    check("btn_cnt", 32'(rst_cnt), 1);

    // Simultaneous WDT and SOFT: WDT wins, one event counted
    wdt_req  = 1'b1;
    soft_req = 1'b1;
    tick();
    wdt_req  = 1'b0;
    soft_req = 1'b0;
    check("sim_e0", 32'(rst_o), 1);
    for (int e = 1; e <= 9; e++) begin
      tick();
      check($sformatf("sim_e%0d", e), 32'(rst_o), (e < 9) ? 1 : 0);
    end
    check("sim_cause", 32'(cause), 2);
    check("sim_cnt", 32'(rst_cnt), 2);

    // SOFT request at hold count 5 restarts the hold
    wdt_req = 1'b1;
    tick();
    wdt_req = 1'b0;
    repeat (6) tick();
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    check("hreq_e0", 32'(rst_o), 1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("hreq_e%0d", e), 32'(rst_o), (e < 8) ? 1 : 0);
    end
    check("hreq_cause", 32'(cause), 3);
    check("hreq_cnt", 32'(rst_cnt), 4);

    // Saturation: 260 watchdog resets
    for (int i = 0; i < 260; i++) begin
      wdt_req = 1'b1;
      tick();
      wdt_req = 1'b0;
      repeat (9) tick();
    end
    check("sat_rst_o", 32'(rst_o), 0);
    check("sat_cause", 32'(cause), 2);
    check("sat_cnt", 32'(rst_cnt), 255);

    // Async clear mid-HOLD
    wdt_req = 1'b1;
    tick();
    wdt_req = 1'b0;
    repeat (3) tick();
    #1 rst = 1'b1;
    #1;
    check("async_hold_rst_o", 32'(rst_o), 1);
    check("async_hold_cause", 32'(cause), 0);
    check("async_hold_cnt", 32'(rst_cnt), 0);

    // Async assertion from RUN raises rst_o without a clock edge
    tick();
    rst = 1'b0;
    repeat (9) tick();
    check("run_before_rst", 32'(rst_o), 0);
    #2 rst = 1'b1;
    #1;
    check("async_run_rst_o", 32'(rst_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
